// File: rtl/s100_pkg.sv
// s100_pkg: shared definitions for the S-100 bus decoder.
//   - ST_* : bit positions inside the i8080 status byte
//   - OPEN_BUS : value returned on reads that hit no slot
//   - WAIT_W / wait_t : width of the per-slot wait-state count
//   - page_match() : base/mask page compare used by every window check
package s100_pkg;

    localparam int ST_INTA  = 0;
    localparam int ST_WO    = 1;
    localparam int ST_STACK = 2;
    localparam int ST_HLTA  = 3;
    localparam int ST_OUT   = 4;
    localparam int ST_M1    = 5;
    localparam int ST_INP   = 6;
    localparam int ST_MEMR  = 7;

    localparam logic [7:0] OPEN_BUS = 8'hFF;

    localparam int WAIT_W = 4;
    typedef logic [WAIT_W-1:0] wait_t;

    // A mask bit of 1 means that page bit takes part in the compare.
    function automatic logic page_match(input logic [7:0] page,
                                        input logic [7:0] base,
                                        input logic [7:0] mask);
        return ((page ^ base) & mask) == 8'h00;
    endfunction

endpackage

// File: rtl/s100_window_match.sv
// s100_window_match: one slot's address window comparator.
//   page    in  8  addr[15:8] of the current cycle
//   base    in  8  slot page base
//   mask    in  8  slot compare mask (1 = bit compared)
//   slot_io in  1  slot lives in the I/O map
//   cyc_io  in  1  current cycle is an I/O cycle
//   hit     out 1  page is inside the window and the map type agrees
module s100_window_match
    import s100_pkg::*;
(
    input  logic [7:0] page,
    input  logic [7:0] base,
    input  logic [7:0] mask,
    input  logic       slot_io,
    input  logic       cyc_io,
    output logic       hit
);

    assign hit = page_match(page, base, mask) && (slot_io == cyc_io);

endmodule

// File: rtl/s100_bus_decoder.sv
// s100_bus_decoder: i8080 -> S-100 slot decoder.
// Latches the status byte on sync, decodes per-slot base/mask windows in the
// memory or I/O map, applies write protection, per-slot wait states and the
// turn-key boot override, and drives open-bus 0xFF on unmapped reads.
//   clk, reset        clock, async active-high reset
//   ce                CPU clock enable (gates all CPU-visible state)
//   addr, odata       CPU address / data-out (status byte while sync=1)
//   sync, rd, wr_n    machine-cycle start, read strobe, write strobe (low)
//   idata, ready      read data and wait control back to the CPU
//   slot_rd, slot_we  per-slot strobes; slot_rdata per-slot read data
//   boot_active       turn-key override in force
//   unmapped          one-clk pulse on an access that hit no slot
module s100_bus_decoder
    import s100_pkg::*;
#(
    parameter int                        N_SLOTS   = 4,
    parameter logic [8*N_SLOTS-1:0]      SLOT_BASE = {N_SLOTS{8'h00}},
    parameter logic [8*N_SLOTS-1:0]      SLOT_MASK = {N_SLOTS{8'hFF}},
    parameter logic [N_SLOTS-1:0]        SLOT_IO   = '0,
    parameter logic [N_SLOTS-1:0]        SLOT_RO   = '0,
    parameter logic [WAIT_W*N_SLOTS-1:0] SLOT_WAIT = '0,
    parameter int                        BOOT_EN   = 1,
    parameter int                        BOOT_SLOT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce,
    input  logic [15:0]            addr,
    input  logic [7:0]             odata,
    input  logic                   sync,
    input  logic                   rd,
    input  logic                   wr_n,
    output logic [7:0]             idata,
    output logic                   ready,
    output logic [N_SLOTS-1:0]     slot_rd,
    output logic [N_SLOTS-1:0]     slot_we,
    input  logic [8*N_SLOTS-1:0]   slot_rdata,
    output logic                   boot_active,
    output logic                   unmapped
);

    localparam int SEL_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam logic [SEL_W-1:0] BOOT_SEL = SEL_W'(BOOT_SLOT);

    localparam logic [N_SLOTS-1:0][7:0]  BASE_A = SLOT_BASE;
    localparam logic [N_SLOTS-1:0][7:0]  MASK_A = SLOT_MASK;
    localparam wait_t [N_SLOTS-1:0]      WAIT_A = SLOT_WAIT;

    logic [N_SLOTS-1:0][7:0] rdata_a;
    assign rdata_a = slot_rdata;

    logic [7:0]   status;
    wait_t        wcnt;
    logic         rd_q, wr_q;

    // Two decodes: one against the latched status (strobes, idata) and one
    // against the status byte arriving on odata (wait-state load at sync).
    logic cyc_io, sync_io;
    assign cyc_io  = status[ST_INP] | status[ST_OUT];
    assign sync_io = odata[ST_INP]  | odata[ST_OUT];

    logic [N_SLOTS-1:0] cur_m, syn_m;

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_win
        s100_window_match u_cur (
            .page(addr[15:8]), .base(BASE_A[g]), .mask(MASK_A[g]),
            .slot_io(SLOT_IO[g]), .cyc_io(cyc_io), .hit(cur_m[g])
        );
        s100_window_match u_syn (
            .page(addr[15:8]), .base(BASE_A[g]), .mask(MASK_A[g]),
            .slot_io(SLOT_IO[g]), .cyc_io(sync_io), .hit(syn_m[g])
        );
    end

    // Priority encoders: lowest matching index wins.
    logic             cur_hit, syn_hit;
    logic [SEL_W-1:0] cur_sel, syn_sel;

    always_comb begin
        cur_hit = 1'b0;
        cur_sel = '0;
        syn_hit = 1'b0;
        syn_sel = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (cur_m[i]) begin
                cur_hit = 1'b1;
                cur_sel = SEL_W'(i);
            end
            if (syn_m[i]) begin
                syn_hit = 1'b1;
                syn_sel = SEL_W'(i);
            end
        end
    end

    // While boot is armed every read goes to the boot slot; writes never do.
    logic             rd_hit;
    logic [SEL_W-1:0] rd_sel;
    assign rd_hit = boot_active | cur_hit;
    assign rd_sel = boot_active ? BOOT_SEL : cur_sel;

    always_comb begin
        slot_rd = '0;
        slot_we = '0;
        if (rd && rd_hit)
            slot_rd[rd_sel] = 1'b1;
        if (!wr_n && cur_hit && !SLOT_RO[cur_sel])
            slot_we[cur_sel] = 1'b1;
    end

    assign idata = rd_hit ? rdata_a[rd_sel] : OPEN_BUS;
    assign ready = (wcnt == '0);

    // Boot disarms on an M1 fetch inside the boot slot's memory window.
    logic boot_win;
    assign boot_win = page_match(addr[15:8], BASE_A[BOOT_SLOT], MASK_A[BOOT_SLOT])
                      && !SLOT_IO[BOOT_SLOT];

    wait_t wload;
    always_comb begin
        wload = '0;
        if (boot_active)
            wload = WAIT_A[BOOT_SLOT];
        else if (syn_hit)
            wload = WAIT_A[syn_sel];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status      <= 8'h00;
            boot_active <= (BOOT_EN != 0);
            wcnt        <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            unmapped    <= 1'b0;
        end else begin
            // Strobe edge detect runs every clk so the pulse is one clk wide.
            rd_q     <= rd;
            wr_q     <= ~wr_n;
            unmapped <= (rd & ~rd_q & ~rd_hit) | (~wr_n & ~wr_q & ~cur_hit);
            if (ce) begin
                if (sync) begin
                    status <= odata;
                    wcnt   <= wload;    // a new cycle overrides any pending wait
                    if (boot_active && odata[ST_M1] && boot_win)
                        boot_active <= 1'b0;
                end else if (wcnt != '0) begin
                    wcnt <= wcnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_s100_bus_decoder.sv
// tb_s100_bus_decoder: randomized scoreboard bench for s100_bus_decoder.
// The stimulus process plays CPU, predicts each access from a slot table and
// pushes the expected response; monitors pop and compare when the DUT shows
// strobes, an unmapped pulse, or the end of a wait stretch.
module tb_s100_bus_decoder;

    localparam int N = 4;
    localparam int BOOTS = 3;

    // Slot table: 0 RAM 00-1F, 1 RAM 20-3F (overlaps 0 below 20, wait 3),
    // 2 I/O ports 00/01/10/11 (wait 2), 3 ROM page FD (read-only, wait 1).
    int m_base[N] = '{8'h00, 8'h20, 8'h00, 8'hFD};
    int m_mask[N] = '{8'hE0, 8'hC0, 8'hEE, 8'hFF};
    int m_io  [N] = '{0, 0, 1, 0};
    int m_ro  [N] = '{0, 0, 0, 1};
    int m_wait[N] = '{0, 3, 2, 1};

    logic        clk = 1'b0;
    logic        reset, ce, sync, rd, wr_n;
    logic [15:0] addr;
    logic [7:0]  odata, idata;
    logic        ready, boot_active, unmapped;
    logic [N-1:0]   slot_rd, slot_we;
    logic [8*N-1:0] slot_rdata;

    s100_bus_decoder #(
        .N_SLOTS(N),
        .SLOT_BASE({8'hFD, 8'h00, 8'h20, 8'h00}),
        .SLOT_MASK({8'hFF, 8'hEE, 8'hC0, 8'hE0}),
        .SLOT_IO(4'b0100),
        .SLOT_RO(4'b1000),
        .SLOT_WAIT({4'd1, 4'd2, 4'd3, 4'd0}),
        .BOOT_EN(1),
        .BOOT_SLOT(BOOTS)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .addr(addr), .odata(odata),
        .sync(sync), .rd(rd), .wr_n(wr_n), .idata(idata), .ready(ready),
        .slot_rd(slot_rd), .slot_we(slot_we), .slot_rdata(slot_rdata),
        .boot_active(boot_active), .unmapped(unmapped)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // ---------------- slot memories (synchronous, 256 bytes each) ----------
    int        seed;
    bit        mem_load = 1'b1;
    logic [7:0] env_mem[N][256];
    logic [7:0] env_rd[N];
    logic [7:0] ref_mem[N][256];

    function automatic logic [7:0] pat(input int s, input int a);
        return 8'((s * 67 + a * 29 + seed) & 255);
    endfunction

    assign slot_rdata = {env_rd[3], env_rd[2], env_rd[1], env_rd[0]};

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (mem_load) begin
                for (int a = 0; a < 256; a++) env_mem[i][a] <= pat(i, a);
                env_rd[i] <= 8'h00;
            end else begin
                if (slot_we[i]) env_mem[i][addr[7:0]] <= odata;
                if (slot_rd[i]) env_rd[i] <= env_mem[i][addr[7:0]];
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [N-1:0] rdv;
        logic [N-1:0] wev;
        logic [7:0]   data;
        bit           unm;
        bit           is_rd;
        string        nm;
    } exp_t;

    exp_t sq[$];
    int   wq[$];
    bit   m_boot;

    function automatic int find(input logic [15:0] a, input int io);
        for (int i = 0; i < N; i++)
            if ((((int'(a[15:8]) ^ m_base[i]) & m_mask[i]) == 0) && m_io[i] == io)
                return i;
        return -1;
    endfunction

    // ---------------- access monitor ----------------
    initial begin
        bit   prev_act = 1'b0;
        bit   pend = 1'b0;
        bit   act;
        exp_t pr, r;
        forever begin
            @(negedge clk);
            act = (slot_rd != '0) || (slot_we != '0);
            if (reset) begin
                pend = 1'b0;
            end else if (pend) begin
                chk({pr.nm, "_idata"}, idata, pr.data);
                chk({pr.nm, "_no_unmapped"}, unmapped, 0);
                pend = 1'b0;
            end else if ((act && !prev_act) || (unmapped && !act)) begin
                if (sq.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_access slot_rd=%b slot_we=%b unmapped=%b", slot_rd, slot_we, unmapped);
                end else begin
                    r = sq.pop_front();
                    chk({r.nm, "_slot_rd"}, slot_rd, r.rdv);
                    chk({r.nm, "_slot_we"}, slot_we, r.wev);
                    chk({r.nm, "_unmapped"}, unmapped, r.unm);
                    if (r.unm && r.is_rd) chk({r.nm, "_openbus"}, idata, 8'hFF);
                    if (!r.unm && r.is_rd) begin pend = 1'b1; pr = r; end
                end
            end
            prev_act = act;
        end
    end

    // ---------------- wait-state monitor: length of each ready-low stretch in ce pulses
    initial begin
        int lowcnt = 0;
        int e;
        forever begin
            @(negedge clk);
            if (reset) lowcnt = 0;
            else if (!ready) begin
                if (ce) lowcnt++;
            end else if (lowcnt > 0) begin
                if (wq.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_wait actual=%0d expected=none", lowcnt);
                end else begin
                    e = wq.pop_front();
                    chk("wait_len", lowcnt, e);
                end
                lowcnt = 0;
            end
        end
    end

    // ---------------- one CPU machine cycle ----------------
    task automatic xact(input logic [7:0] st, input logic [15:0] a, input bit wr,
                        input logic [7:0] wd, input string nm);
        int   io, s, ws, rs, n;
        bit   ro = 1'b0;
        exp_t r;
        io = (st[6] | st[4]) ? 1 : 0;
        s  = find(a, io);
        ws = m_boot ? BOOTS : s;
        if (ws >= 0 && m_wait[ws] > 0) wq.push_back(m_wait[ws]);
        if (m_boot && st[5] && m_io[BOOTS] == 0 &&
            (((int'(a[15:8]) ^ m_base[BOOTS]) & m_mask[BOOTS]) == 0))
            m_boot = 1'b0;
        r.nm = nm; r.rdv = '0; r.wev = '0; r.data = 8'h00; r.unm = 1'b0; r.is_rd = !wr;
        if (!wr) begin
            rs = m_boot ? BOOTS : s;
            if (rs < 0) r.unm = 1'b1;
            else begin
                r.rdv[rs] = 1'b1;
                r.data = ref_mem[rs][a[7:0]];
            end
            sq.push_back(r);
        end else if (s < 0) begin
            r.unm = 1'b1;
            sq.push_back(r);
        end else if (m_ro[s] != 0) begin
            ro = 1'b1;
        end else begin
            r.wev[s] = 1'b1;
            ref_mem[s][a[7:0]] = wd;
            sq.push_back(r);
        end

        addr = a; odata = st; sync = 1'b1; ce = 1'b1;
        @(posedge clk); #1;
        sync = 1'b0; odata = wd;
        n = 0;
        while (!ready && n < 64) begin
            ce = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        if (!ready) begin
            checks++; fails++;
            $display("FAIL %s_ready_timeout actual=ready0 expected=ready1", nm);
        end
        ce = 1'b1;
        if (wr) wr_n = 1'b0; else rd = 1'b1;
        if (ro) begin #2; chk({nm, "_ro_we"}, slot_we, 0); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd = 1'b0; wr_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pg[10] = '{8'h00, 8'h01, 8'h1F, 8'h20, 8'h3F, 8'h40, 8'h80, 8'hFD, 8'hFE, 8'h12};
        int pio[5] = '{8'h10, 8'h11, 8'h00, 8'h80, 8'h01};
        logic [7:0] st, p, wd;
        int k;

        seed = int'($urandom_range(0, 255));
        for (int i = 0; i < N; i++)
            for (int a = 0; a < 256; a++) ref_mem[i][a] = pat(i, a);
        reset = 1'b1; ce = 1'b1; sync = 1'b0; rd = 1'b0; wr_n = 1'b1;
        addr = 16'h0000; odata = 8'h00;
        m_boot = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_load = 1'b0;
        @(negedge clk);
        chk("reset_ready", ready, 1);
        chk("reset_boot_active", boot_active, 1);
        chk("reset_unmapped", unmapped, 0);
        chk("reset_slot_rd", slot_rd, 0);
        chk("reset_slot_we", slot_we, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        // Turn-key boot: low reads land in the ROM until the M1 fetch at FD00.
        xact(8'hA2, 16'h0000, 0, 8'h00, "boot_rd0");
        xact(8'h82, 16'h0001, 0, 8'h00, "boot_rd1");
        xact(8'h82, 16'h0002, 0, 8'h00, "boot_rd2");
        xact(8'hA2, 16'hFD00, 0, 8'h00, "boot_m1_fd00");
        chk("boot_cleared", boot_active, 0);
        xact(8'h82, 16'h0000, 0, 8'h00, "ram_rd0");

        // Memory map, I/O map, read-only, wait states, unmapped, overlap.
        xact(8'h00, 16'h1234, 1, 8'h5A, "ram_wr1234");
        xact(8'h82, 16'h1234, 0, 8'h00, "ram_rd1234");
        xact(8'h40, 16'h1010, 0, 8'h00, "io_in10");
        xact(8'h10, 16'h1010, 1, 8'h77, "io_out10");
        xact(8'h00, 16'hFD00, 1, 8'h11, "rom_wr");
        xact(8'h82, 16'hFD00, 0, 8'h00, "rom_rd");
        xact(8'h82, 16'h2000, 0, 8'h00, "wait3_rd");
        xact(8'h82, 16'h8000, 0, 8'h00, "unm_rd8000");
        xact(8'h00, 16'h8000, 1, 8'hC3, "unm_wr8000");
        xact(8'h82, 16'h0100, 0, 8'h00, "overlap_rd");

        // Reset during a wait stretch clears ready at once and re-arms boot.
        addr = 16'h2000; odata = 8'h82; sync = 1'b1; ce = 1'b1;
        @(posedge clk); #1 sync = 1'b0;
        chk("midwait_ready_low0", ready, 0);
        @(posedge clk); #1;
        chk("midwait_ready_low1", ready, 0);
        reset = 1'b1;
        #1;
        chk("midwait_reset_ready", ready, 1);
        chk("midwait_reset_boot", boot_active, 1);
        m_boot = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        // Randomized machine cycles; boot stays armed until a random FD fetch.
        for (int t = 0; t < 300; t++) begin
            k  = int'($urandom_range(0, 4));
            wd = 8'($urandom);
            if (k >= 3) begin
                p  = 8'(pio[$urandom_range(0, 4)]);
                st = (k == 3) ? 8'h40 : 8'h10;
                xact(st, {p, p}, k == 4, wd, (k == 3) ? "rnd_in" : "rnd_out");
            end else begin
                p = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(pg[$urandom_range(0, 9)]);
                st = (k == 0) ? 8'h82 : (k == 1) ? 8'hA2 : 8'h00;
                xact(st, {p, 8'($urandom)}, k == 2, wd,
                     (k == 0) ? "rnd_rd" : (k == 1) ? "rnd_m1" : "rnd_wr");
            end
            repeat ($urandom_range(0, 2)) begin
                ce = 1'b0;
                @(posedge clk); #1;
            end
            ce = 1'b1;
        end

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", sq.size(), 0);
        chk("wait_queue_drained", wq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
